// File: rtl/adder2_serial_acc.sv
// adder2_serial_acc: digit-serial adder that processes two operand bits per clock.
// One 2-bit adder slice with a registered carry walks the operands LSB digit first.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake for a, b (and sub when enabled)
//   a, b                WIDTH-bit unsigned operands
//   out_valid/out_ready result handshake for sum, cout
//   sum, cout           {cout,sum} = a+b (or a-b mod 2^WIDTH when sub=1)
//
// Optional feature macro: ADDER2_SUB_EN
//   Adds input port sub. With sub=1, B digits are inverted before the slice and
//   the initial carry is 1, giving a-b mod 2^WIDTH; cout=1 means no borrow.

// 2-bit adder slice: r = a_dig + b_dig + cin, with r[2] as carry out.
module adder2_slice (
  input  logic [1:0] a_dig,
  input  logic [1:0] b_dig,
  input  logic       cin,
  output logic [2:0] r
);

  assign r = {1'b0, a_dig} + {1'b0, b_dig} + {2'b00, cin};

endmodule

module adder2_serial_acc #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ADDER2_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned DIGITS = WIDTH / 2;
  localparam int unsigned CNT_W  = $clog2(DIGITS) + 1;

  // Odd or too-small widths cannot be split into 2-bit digits.
  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("adder2_serial_acc: WIDTH must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic [WIDTH-1:0]   a_q,         a_d;
  logic [WIDTH-1:0]   b_q,         b_d;
  logic [WIDTH-1:0]   res_q,       res_d;
  logic               carry_q,     carry_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               in_ready_q,  in_ready_d;
  logic               out_valid_q, out_valid_d;

  // Subtract control: latched with the operands, constant 0 when the feature is absent.
  logic               sub_in_c;
  logic               sub_act_c;
`ifdef ADDER2_SUB_EN
  logic               sub_q,       sub_d;

  assign sub_in_c  = sub;
  assign sub_act_c = sub_q;
`else
  assign sub_in_c  = 1'b0;
  assign sub_act_c = 1'b0;
`endif

  // Slice operands: low digit of each shift register, B inverted for subtract.
  logic [1:0] slice_b_c;
  logic [2:0] slice_r_c;

  assign slice_b_c = sub_act_c ? ~b_q[1:0] : b_q[1:0];

  adder2_slice u_slice (
    .a_dig (a_q[1:0]),
    .b_dig (slice_b_c),
    .cin   (carry_q),
    .r     (slice_r_c)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
`ifdef ADDER2_SUB_EN
    sub_d    = sub_q;
`endif

    case (state_q)
      IDLE: begin
        // Operands are only loaded on a real accept, so X on idle inputs stays out.
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = sub_in_c;
          cnt_d   = '0;
`ifdef ADDER2_SUB_EN
          sub_d   = sub;
`endif
          state_d = RUN;
        end
      end

      RUN: begin
        carry_d = slice_r_c[2];
        // New digit enters at the top; after DIGITS shifts it sits in place.
        res_d   = WIDTH'({slice_r_c[1:0], res_q} >> 2);
        a_d     = a_q >> 2;
        b_d     = b_q >> 2;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIGITS - 1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake flags are registered copies of the upcoming state.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ADDER2_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef ADDER2_SUB_EN
      sub_q       <= sub_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = res_q;
  assign cout      = carry_q;

endmodule

// File: tb/tb_adder2_serial_acc.sv
// Self-checking bench for adder2_serial_acc: WIDTH=8 directed and random
// operations plus an exhaustive WIDTH=2 instance, against an arithmetic model.
module tb_adder2_serial_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;

  // WIDTH=8 instance signals
  logic       in_valid, out_ready;
  logic [7:0] a, b;
  logic       in_ready, out_valid, cout;
  logic [7:0] sum;

  // WIDTH=2 instance signals
  logic       in_valid2, out_ready2;
  logic [1:0] a2, b2;
  logic       in_ready2, out_valid2, cout2;
  logic [1:0] sum2;

`ifdef ADDER2_SUB_EN
  logic sub;
  logic sub2;
`endif

  int checks = 0;
  int errors = 0;

  adder2_serial_acc #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
`ifdef ADDER2_SUB_EN
    .sub       (sub),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  adder2_serial_acc #(.WIDTH(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
`ifdef ADDER2_SUB_EN
    .sub       (sub2),
`endif
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .a         (a2),
    .b         (b2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .sum       (sum2),
    .cout      (cout2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout,sum} from plain integer arithmetic.
  function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic s);
    int t;
    if (s) begin
      t = int'(x) - int'(y);
      return {(t >= 0) ? 1'b1 : 1'b0, 8'(t + 256)};
    end
    t = int'(x) + int'(y);
    return 9'(t);
  endfunction

  function automatic logic [2:0] model2(input logic [1:0] x, input logic [1:0] y);
    int t;
    t = int'(x) + int'(y);
    return 3'(t);
  endfunction

  // One WIDTH=8 operation: accept, latency, result, stall, release.
  task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input logic sv, input int stall);
    logic [8:0] exp;
    int lat;
    exp = model8(av, bv, sv);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    a = av;
    b = bv;
`ifdef ADDER2_SUB_EN
    sub = sv;
`endif
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 'x;
    b = 'x;
    chk("run_in_ready", 32'(in_ready), 32'd0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd4);
    chk("sum", 32'(sum), 32'(exp[7:0]));
    chk("cout", 32'(cout), 32'(exp[8]));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      a = 8'($urandom);
      b = 8'($urandom);
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_sum", 32'(sum), 32'(exp[7:0]));
      chk("stall_cout", 32'(cout), 32'(exp[8]));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  // One WIDTH=2 operation: RUN must last exactly one cycle.
  task automatic run_op2(input logic [1:0] av, input logic [1:0] bv);
    logic [2:0] exp;
    int lat;
    exp = model2(av, bv);
    chk("w2_idle_in_ready", 32'(in_ready2), 32'd1);
    a2 = av;
    b2 = bv;
    in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    chk("w2_run_valid", 32'(out_valid2), 32'd0);
    lat = 0;
    while (out_valid2 !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("w2_latency", 32'(lat), 32'd1);
    chk("w2_sum", 32'(sum2), 32'(exp[1:0]));
    chk("w2_cout", 32'(cout2), 32'(exp[2]));
    out_ready2 = 1'b1;
    @(negedge clk);
    out_ready2 = 1'b0;
    chk("w2_release_valid", 32'(out_valid2), 32'd0);
  endtask

  initial begin
    int seen_valid;
    logic rs;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    in_valid2 = 1'b0;
    out_ready2 = 1'b0;
    a2 = '0;
    b2 = '0;
`ifdef ADDER2_SUB_EN
    sub = 1'b0;
    sub2 = 1'b0;
`endif

    // Reset held two cycles, then released
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_sum", 32'(sum), 32'h00);
    chk("post_rst_cout", 32'(cout), 32'd0);

    // Directed operations
    run_op8(8'h3C, 8'h05, 1'b0, 0);
    run_op8(8'hFF, 8'h01, 1'b0, 0);
    run_op8(8'hAA, 8'h55, 1'b0, 1);
    run_op8(8'h80, 8'h80, 1'b0, 10);

    // Reset after two digits discards the partial result
    a = 8'h37;
    b = 8'h11;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
    chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    chk("midrun_rst_sum", 32'(sum), 32'h00);
    chk("midrun_rst_cout", 32'(cout), 32'd0);
    seen_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen_valid++;
    end
    chk("midrun_no_valid", 32'(seen_valid), 32'd0);
    run_op8(8'h01, 8'h01, 1'b0, 0);

`ifdef ADDER2_SUB_EN
    run_op8(8'h05, 8'h07, 1'b1, 0);
    run_op8(8'h07, 8'h05, 1'b1, 2);
    run_op8(8'h00, 8'h00, 1'b1, 0);
`endif

    // Random operations with random backpressure
    for (int i = 0; i < 24; i++) begin
      rs = 1'b0;
`ifdef ADDER2_SUB_EN
      rs = 1'($urandom_range(0, 1));
`endif
      run_op8(8'($urandom), 8'($urandom), rs, int'($urandom_range(0, 3)));
    end

    // WIDTH=2: exhaustive operand pairs
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        run_op2(2'(x), 2'(y));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
